mult: RTL and testbench
=======================

// Module: mult
// PURPOSE
//  Pipelined modular multiplier for the Kyber datapath: out = (in1 * in2) mod Q, with Q = 3329.
//  Feeds the NTT butterfly and the pointwise-multiply units.
//  Reduction uses Barrett, with no divider. Fully pipelined: accepts a new operand pair every clock.
// PARAMETERS
//  W        12     operand/result width
//  Q        3329   modulus (Kyber q)
//  K        24     Barrett shift, 2*W
//  M        5039   Barrett constant, floor(2^K / Q)
// PORTS
//  clk   input   1   single clock, rising-edge
//  rst   input   1   reset, asynchronous, active-high
//  out   output  W   registered result, (in1*in2) mod Q
//  in1   input   W   operand A, any 12-bit value (0..4095)
//  in2   input   W   operand B, any 12-bit value (0..4095)
//  Positional instantiation order is fixed: (out, in1, in2, clk, rst).
// BEHAVIOUR
//  - Reset:
//    - Asynchronous, active-high.
//    - While rst=1, every pipeline register and out are 0.
//    - Reset asserted mid-operation discards all in-flight products.
//    - out stays 0 until 3 rising edges after rst falls.
//  - Latency is 3 clocks, throughput 1/clk, no handshake. in1/in2 are sampled on every rising edge.
//  - S1: register p = in1*in2 as a 2W = 24-bit unsigned value (max 4095^2 = 16769025 < 2^24).
//  - S2, quotient estimate:
//    - qe = (p * M) >> K, using a 37-bit intermediate, truncated to 13 bits.
//    - r = p - qe*Q, kept 14 bits wide.
//    - Register r and nothing else.
//  - S3, final reduction:
//    - r is guaranteed in [0, 3Q).
//    - If r >= 2Q, subtract 2Q. Else if r >= Q, subtract Q.
//    - Register the low W bits as out.
//  - out is always in [0, Q-1] after the pipe fills.
//  - Operands >= Q are legal and reduce correctly, because reduction is on the full product.
//  - All arithmetic is unsigned. Overflow is not possible given the widths above.
//  - Every stage updates every cycle. There is no enable and no valid signal; downstream tracks latency.
// STRUCTURE
//  - Shared package kyber_pkg holds:
//    - localparams KYBER_Q = 3329, KYBER_W = 12, BARRETT_K = 24, BARRETT_M = 5039.
//    - function barrett_est(p) returning qe.
//  - One sub-module is natural: barrett_reduce. It is a 24-bit product in, W-bit residue out, 2 register stages (S2, S3).
//  - mult = product register (S1) + barrett_reduce.
// TESTING
//  1. rst=1 with any inputs -> out=0. Release rst, hold in1=10, in2=300 -> out=3000 exactly 3 clocks later.
//  2. in1=3300, in2=3290 -> out=1131. Then in1=3000, in2=3111 -> out=1813. Then in1=200, in2=10 -> out=2000.
//     Each result appears 3 clocks after its inputs, and the operand pairs are applied on back-to-back cycles.
//  3. Corner operands:
//     - in1=3328, in2=3328 -> 1.
//     - in1=4095, in2=4095 -> 852.
//     - in1=0, in2=x -> 0.
//     - in1=1, in2=3329 -> 0.
//     - in1=1, in2=3328 -> 3328.
//  4. Assert rst asynchronously (between clock edges) while the pipe is full -> out=0 immediately.
//     Release -> out stays 0 for 3 edges, then resumes correct results.
//  5. Random sweep of 10k pairs over 0..4095, scoreboard against (a*b)%3329 delayed 3 cycles.
//     Assert out < 3329 on every cycle after the fill.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants, datapath types and the Barrett quotient estimate.
package kyber_pkg;

  localparam int unsigned KYBER_Q   = 3329;
  localparam int unsigned KYBER_W   = 12;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned BARRETT_M = 5039;

  typedef logic [KYBER_W-1:0]   coeff_t;
  typedef logic [2*KYBER_W-1:0] prod_t;
  typedef logic [KYBER_W:0]     quot_t;
  typedef logic [13:0]          resid_t;

  // qe = floor(p * M / 2^K); it never exceeds the true quotient, so p - qe*Q >= 0
  function automatic quot_t barrett_est(input prod_t p);
    logic [36:0] wide;
    wide = {13'd0, p} * 37'(BARRETT_M);
    return quot_t'(wide >> BARRETT_K);
  endfunction

endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction: 24-bit product in, residue mod Q out.
// Stage S2 registers the coarse residue, stage S3 registers the fully reduced value.
module barrett_reduce
  import kyber_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  prod_t  p_i,
  output coeff_t res_o
);

  resid_t r_d, r_q;
  coeff_t res_d, res_q;

  // Coarse residue is below 3Q, so 14 bits hold it exactly and the truncation is lossless
  always_comb begin
    r_d = resid_t'(p_i - {11'd0, barrett_est(p_i)} * prod_t'(KYBER_Q));
  end

  always_comb begin
    res_d = '0;
    if (r_q >= resid_t'(2 * KYBER_Q)) begin
      res_d = coeff_t'(r_q - resid_t'(2 * KYBER_Q));
    end else if (r_q >= resid_t'(KYBER_Q)) begin
      res_d = coeff_t'(r_q - resid_t'(KYBER_Q));
    end else begin
      res_d = coeff_t'(r_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      res_q <= '0;
    end else begin
      r_q   <= r_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/mult.sv
// Pipelined modular multiplier, out = (in1 * in2) mod 3329, three-cycle latency, one result per clock.
// S1 registers the full product; barrett_reduce supplies S2 and S3.
module mult
  import kyber_pkg::*;
#(
  parameter int W = KYBER_W
) (
  output logic [W-1:0] out,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         clk,
  input  logic         rst
);

  prod_t  p_d, p_q;
  coeff_t res;

  always_comb begin
    p_d = prod_t'(in1) * prod_t'(in2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  barrett_reduce u_barrett_reduce (
    .clk   (clk),
    .rst   (rst),
    .p_i   (p_q),
    .res_o (res)
  );

  assign out = res;

endmodule

// File: tb/tb_mult.sv
// Directed and random checks for the mult pipeline; inputs change and out is sampled on falling edges.
module tb_mult;

  logic        clk;
  logic        rst;
  logic [11:0] in1;
  logic [11:0] in2;
  logic [11:0] out;

  int n_cmp;
  int n_err;

  mult dut (
    .out (out),
    .in1 (in1),
    .in2 (in2),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Directed back-to-back operand pairs with hand-computed residues
  localparam int N_DIR = 9;
  int dir_a [N_DIR] = '{3300, 3000, 200, 3328, 4095,    0,    0,    1,    1};
  int dir_b [N_DIR] = '{3290, 3111,  10, 3328, 4095, 4095, 1234, 3329, 3328};
  int dir_e [N_DIR] = '{1131, 1813, 2000,    1,  852,    0,    0,    0, 3328};

  int exp_q[$];
  int a, b, e;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in1 = 12'd1234;
    in2 = 12'd4000;

    // Reset holds out at zero regardless of inputs
    repeat (3) begin
      @(negedge clk);
      check("reset_out", int'(out), 0);
      in1 = 12'($urandom_range(0, 4095));
      in2 = 12'($urandom_range(0, 4095));
    end

    // Release, hold 10*300: zero for two edges, 3000 after the third
    @(negedge clk);
    rst = 1'b0;
    in1 = 12'd10;
    in2 = 12'd300;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("fill_edge%0d", i), int'(out), (i == 3) ? 3000 : 0);
    end

    // Back-to-back directed vectors
    for (int i = 0; i < N_DIR + 3; i++) begin
      if (i >= 3) check($sformatf("dir%0d", i - 3), int'(out), dir_e[i - 3]);
      if (i < N_DIR) begin
        in1 = 12'(dir_a[i]);
        in2 = 12'(dir_b[i]);
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-stream with a full pipe
    in1 = 12'd4095;
    in2 = 12'd4095;
    repeat (3) @(negedge clk);
    check("prefill", int'(out), 852);
    in1 = 12'd3000;
    in2 = 12'd3111;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", int'(out), 0);
    @(negedge clk);
    check("rst_hold", int'(out), 0);
    rst = 1'b0;
    in1 = 12'd3328;
    in2 = 12'd3328;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("refill_edge%0d", i), int'(out), (i == 3) ? 1 : 0);
    end

    // Random sweep against a plain modulo model delayed three cycles
    exp_q.delete();
    for (int i = 0; i < 10000 + 3; i++) begin
      if (i >= 3) begin
        e = exp_q.pop_front();
        check("rand", int'(out), e);
        check("range", int'(out < 12'd3329), 1);
      end
      if (i < 10000) begin
        a = int'($urandom_range(0, 4095));
        b = int'($urandom_range(0, 4095));
        in1 = 12'(a);
        in2 = 12'(b);
        exp_q.push_back((a * b) % 3329);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
